mem_arbiter: RTL and testbench

// Shares the single-ported RAM between the fetch requester (iREN) and the data requester (dREN/dWEN).
// The data requester's enables come from the control unit's lw/sw decode.

---
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter between fetch and data requesters
// Data has priority; a streak limit forces one fetch grant after MAX_DSTREAK data grants.
module mem_arbiter #(
    parameter int TIMEOUT     = 16,
    parameter int MAX_DSTREAK = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    input  logic [1:0]  ramstate,
    input  logic [31:0] ramload,
    output logic        iwait,
    output logic        dwait,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    output logic        bus_err
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);
    localparam logic [SW-1:0] DSTREAK_MAX = SW'(MAX_DSTREAK);

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {IDLE, DGNT, IGNT} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [SW-1:0] dstreak_q, dstreak_d;
    logic          bus_err_q, bus_err_d;

    logic dreq, done, fail;

    assign dreq    = dREN | dWEN;
    assign done    = (ramstate == RAM_ACCESS);
    assign fail    = (ramstate == RAM_ERROR) || (tcnt_q == TCNT_LAST);
    assign bus_err = bus_err_q;

    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        dstreak_d = dstreak_q;
        bus_err_d = bus_err_q;
        iwait     = iREN;
        dwait     = dreq;
        iload     = '0;
        dload     = '0;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;
        case (state_q)
            IDLE: begin
                if (!iREN)
                    dstreak_d = '0;
                if (dreq && !(iREN && dstreak_q == DSTREAK_MAX))
                    state_d = DGNT;
                else if (iREN)
                    state_d = IGNT;
            end
            DGNT: begin
                iwait    = 1'b1;
                dwait    = 1'b1;
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (!dreq) begin
                    state_d = IDLE;
                end else if (done) begin
                    dwait   = 1'b0;
                    dload   = dWEN ? '0 : ramload;
                    state_d = IDLE;
                    if (iREN && dstreak_q != DSTREAK_MAX)
                        dstreak_d = dstreak_q + 1'b1;
                end else if (fail) begin
                    dwait     = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            IGNT: begin
                iwait   = 1'b1;
                dwait   = 1'b1;
                ramaddr = iaddr;
                ramREN  = iREN;
                if (!iREN) begin
                    state_d = IDLE;
                end else if (done) begin
                    iwait     = 1'b0;
                    iload     = ramload;
                    dstreak_d = '0;
                    state_d   = IDLE;
                end else if (fail) begin
                    iwait     = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Timeout count restarts for every new grant.
        if (state_d == IDLE)
            tcnt_d = '0;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            tcnt_q    <= '0;
            dstreak_q <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
            dstreak_q <= dstreak_d;
            bus_err_q <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, bus_err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    mem_arbiter #(.TIMEOUT(16), .MAX_DSTREAK(4)) dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
        .daddr(daddr), .dstore(dstore), .ramstate(ramstate), .ramload(ramload),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .bus_err(bus_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge; inputs change there.
    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic drive(input logic ir, input logic dr, input logic dw, input logic [1:0] rs);
        iREN = ir; dREN = dr; dWEN = dw; ramstate = rs;
        #1;
    endtask

    initial begin
        nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = FREE;
        #12;
        chk("rst_ramREN", ramREN, 0);
        chk("rst_ramWEN", ramWEN, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_ramaddr", ramaddr, 0);
        nRST = 1'b1;

        // 1) single fetch, ACCESS on first drive
        step(); iaddr = 32'h40; drive(1, 0, 0, FREE);
        chk("t1_idle_iwait", iwait, 1);
        chk("t1_idle_ramREN", ramREN, 0);
        step(); ramload = 32'hDEADBEEF; drive(1, 0, 0, ACCESS);
        chk("t1_ramREN", ramREN, 1);
        chk("t1_ramaddr", ramaddr, 32'h40);
        chk("t1_iwait", iwait, 0);
        chk("t1_iload", iload, 32'hDEADBEEF);
        step(); drive(0, 0, 0, FREE);
        chk("t1_back_idle", ramREN, 0);

        // 2) simultaneous fetch and write: data first, BUSY twice then ACCESS
        step(); daddr = 32'h80; dstore = 32'h1234; iaddr = 32'h44; drive(1, 0, 1, BUSY);
        step(); drive(1, 0, 1, BUSY);
        chk("t2_ramWEN", ramWEN, 1);
        chk("t2_ramREN", ramREN, 0);
        chk("t2_ramaddr", ramaddr, 32'h80);
        chk("t2_ramstore", ramstore, 32'h1234);
        chk("t2_dwait_c1", dwait, 1);
        chk("t2_iwait_c1", iwait, 1);
        step(); drive(1, 0, 1, BUSY);
        chk("t2_dwait_c2", dwait, 1);
        step(); ramload = 32'h5555; drive(1, 0, 1, ACCESS);
        chk("t2_dwait_c3", dwait, 0);
        chk("t2_dload_write", dload, 0);
        step(); drive(1, 0, 0, FREE);
        chk("t2_idle_ramWEN", ramWEN, 0);
        chk("t2_idle_ramREN", ramREN, 0);
        step(); ramload = 32'h0BADF00D; drive(1, 0, 0, ACCESS);
        chk("t2_fetch_ramaddr", ramaddr, 32'h44);
        chk("t2_fetch_iwait", iwait, 0);
        chk("t2_fetch_iload", iload, 32'h0BADF00D);
        step(); drive(0, 0, 0, FREE);

        // 3) fetch held alongside data reads: pattern D D D D I repeated
        iaddr = 32'h100; daddr = 32'h200;
        for (int i = 0; i < 10; i++) begin
            step(); drive(1, 1, 0, FREE);
            step(); ramload = 32'h1000 + i; drive(1, 1, 0, ACCESS);
            if (i % 5 == 4) begin
                chk($sformatf("t3_g%0d_addr", i), ramaddr, 32'h100);
                chk($sformatf("t3_g%0d_iwait", i), iwait, 0);
                chk($sformatf("t3_g%0d_dwait", i), dwait, 1);
            end else begin
                chk($sformatf("t3_g%0d_addr", i), ramaddr, 32'h200);
                chk($sformatf("t3_g%0d_iwait", i), iwait, 1);
                chk($sformatf("t3_g%0d_dload", i), dload, 32'h1000 + i);
            end
        end
        step(); drive(0, 0, 0, FREE);

        // 4) data read held BUSY until timeout
        step(); daddr = 32'h300; ramload = 32'hAAAA_AAAA; drive(0, 1, 0, BUSY);
        for (int k = 0; k < 15; k++) begin
            step(); drive(0, 1, 0, BUSY);
            chk($sformatf("t4_dwait_%0d", k), dwait, 1);
        end
        step(); drive(0, 1, 0, BUSY);
        chk("t4_timeout_dwait", dwait, 0);
        chk("t4_timeout_dload", dload, 0);
        step(); iaddr = 32'h48; drive(1, 0, 0, FREE);
        chk("t4_bus_err", bus_err, 1);
        chk("t4_idle_ramREN", ramREN, 0);
        step(); ramload = 32'h55; drive(1, 0, 0, ACCESS);
        chk("t4_next_ramaddr", ramaddr, 32'h48);
        chk("t4_next_iload", iload, 32'h55);
        step(); drive(0, 0, 0, FREE);
        chk("t4_err_sticky", bus_err, 1);

        // 5) ERROR during fetch grant
        nRST = 1'b0; #1;
        chk("t5_rst_clears_err", bus_err, 0);
        nRST = 1'b1;
        step(); iaddr = 32'h60; drive(1, 0, 0, FREE);
        step(); ramload = 32'h77; drive(1, 0, 0, ERROR);
        chk("t5_iwait", iwait, 0);
        chk("t5_iload", iload, 0);
        step(); drive(0, 0, 0, FREE);
        chk("t5_bus_err", bus_err, 1);
        step(); drive(1, 0, 0, FREE);
        step(); drive(1, 0, 0, ACCESS);
        chk("t5_good_iwait", iwait, 0);
        step(); drive(0, 0, 0, FREE);
        chk("t5_err_stays", bus_err, 1);

        // 6) async reset mid-write
        step(); daddr = 32'h90; drive(0, 0, 1, BUSY);
        step(); drive(0, 0, 1, BUSY);
        chk("t6_ramWEN_before", ramWEN, 1);
        nRST = 1'b0; #1;
        chk("t6_ramWEN_in_rst", ramWEN, 0);
        chk("t6_bus_err_rst", bus_err, 0);
        step(); nRST = 1'b1; drive(0, 0, 0, FREE);
        chk("t6_ramWEN_after", ramWEN, 0);

        // Reset also clears the data streak: build it to the limit, reset, data still wins
        daddr = 32'h210; iaddr = 32'h110;
        for (int i = 0; i < 4; i++) begin
            step(); drive(1, 1, 0, FREE);
            step(); drive(1, 1, 0, ACCESS);
        end
        step(); drive(0, 0, 0, FREE);
        iREN = 1'b1; nRST = 1'b0; #1; nRST = 1'b1;
        drive(1, 1, 0, FREE);
        step(); drive(1, 1, 0, ACCESS);
        chk("t6_streak_cleared", ramaddr, 32'h210);
        step(); drive(0, 0, 0, FREE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
